// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared types and helpers for the bit-serial subtractor.
//                Holds the controller state encoding, the default operand
//                width and the signed-overflow rule for a - b.
//  Revision    : 1.0  initial release
// ============================================================================
package sub_pkg;

  // Default operand / result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states, fixed 2-bit encoding (11 is unused).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Signed overflow of a - b: operands of different sign and the result sign
  // differs from the minuend sign.
  function automatic logic sub_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Combinational 1-bit full subtractor, diff = a - b - bin.
//                bout is raised when the bit position needs to borrow.
//                Used as the single bit slice of the serial subtractor and
//                suitable for chaining into a ripple subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
module full_subtractor
  import sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference bit is the parity of the three inputs.
  assign diff = a ^ b ^ bin;

  // Borrow when b exceeds a, or when a == b and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial two's-complement subtractor, diff = a - b.
//                Operands are latched on an accepted start, processed LSB
//                first through one full-subtractor cell and a borrow flop,
//                and the result with unsigned borrow and signed overflow is
//                presented alongside a one-cycle done strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Controller state
  state_e           state_q, state_d;

  // Operand shift registers, partial result and bit counter
  logic [WIDTH-1:0] sra_q, sra_d;
  logic [WIDTH-1:0] srb_q, srb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;

  // Operand sign bits kept for the overflow decision
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;

  // Result registers presented on the outputs
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Bit-slice outputs and control decodes
  logic             cell_diff;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  full_subtractor u_bit_slice (
    .a    (sra_q[0]),
    .b    (srb_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // State register; reset returns the controller to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured outside SHIFT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per SHIFT cycle,
  // and publish the result registers on the final bit.
  always_comb begin
    sra_d    = sra_q;
    srb_d    = srb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    if (accept) begin
      sra_d  = a;
      srb_d  = b;
      br_d   = 1'b0;
      cnt_d  = '0;
      amsb_d = a[WIDTH-1];
      bmsb_d = b[WIDTH-1];
    end else if (state_q == SHIFT) begin
      sra_d = {1'b0, sra_q[WIDTH-1:1]};
      srb_d = {1'b0, srb_q[WIDTH-1:1]};
      res_d = {cell_diff, res_q[WIDTH-1:1]};
      br_d  = cell_bout;
      cnt_d = cnt_q + CNT_ONE;
      if (last_bit) begin
        // The completed result already includes this cycle's bit.
        diff_d   = res_d;
        borrow_d = cell_bout;
        ovf_d    = sub_overflow(amsb_q, bmsb_q, cell_diff);
      end
    end
  end

  // Datapath registers; reset clears everything including the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sra_q    <= '0;
      srb_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sra_q    <= sra_d;
      srb_q    <= srb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire
